mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Pipeline stage between EX and WB of the 5-stage MIPS core. Registers the EX->MEM bus.
//  Selects and extends load data returned by the synchronous data SRAM (lb/lbu/lh/lhu/lw).
//  Drives the MEM->WB bus, and drives mem_to_id_bus, the MEM-stage bypass into the regfile read ports.
//  Holds the SRAM read data stable across MEM stalls.
// PARAMETERS
//  none; bus widths come from defines.vh (EX_TO_MEM_WD=79, MEM_TO_WB_WD=70, StallBus=6)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  resetn          in   1   synchronous reset, active-low
//  stall           in   6   stall bus; [3]=MEM held, [4]=WB held
//  flush           in   1   kill MEM contents (exception/eret); priority over stall
//  ex_to_mem_bus   in   79  {pc[78:47], ram_en[46], ram_wen[45:42], sel_rf_res[41], rf_we[40], rf_waddr[39:35], load_type[34:32], ex_result[31:0]}
//  data_sram_rdata in   32  SRAM read data; valid in the cycle after the EX-stage request
//  mem_to_wb_bus   out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
//  mem_to_id_bus   out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}; same fields as WB bus
// BEHAVIOUR
//  - Reset: resetn==0 at posedge clears the pipeline register and the hold buffer.
//    All outputs read 0 in the next cycle (rf_we=0, pc=0).
//  - Pipeline register update, first match wins:
//      !resetn or flush       -> clear
//      stall[3] & !stall[4]   -> clear (bubble into WB)
//      !stall[3]              -> load ex_to_mem_bus
//      else                   -> hold
//  - Latency: 1 cycle EX->MEM register; all outputs are combinational from register + rdata.
//  - load_type: 0=none, 1=lb, 2=lbu, 3=lh, 4=lhu, 5=lw; 6,7 treated as none.
//    Offset is ex_result[1:0].
//  - lb/lbu: byte = rdata[8*off +: 8], then sign- or zero-extend to 32 bits.
//  - lh/lhu: half = rdata[16*off[1] +: 16], then sign- or zero-extend. off[0] is ignored; EX owns alignment exceptions.
//  - rf_wdata = (ram_en & sel_rf_res & load_type!=none) ? extended load data : ex_result.
//  - Hold buffer:
//      capture: set hold_valid, hold_data<=data_sram_rdata on a posedge where the register holds a load (ram_en & sel_rf_res), stall[3]=1, and hold_valid=0.
//      use: while hold_valid=1, hold_data replaces data_sram_rdata.
//      clear: hold_valid clears on any register load, bubble, flush or reset.
//  - Store instructions (ram_wen!=0) pass with rf_we from the bus; EX has already issued the store.
//  - flush and stall in the same cycle: flush wins; the register clears and the hold buffer clears.
//  - Bubble: rf_we=0 forces mem_to_id_bus inactive, so the regfile never forwards a stale value.
// STRUCTURE
//  - defines.vh: EX_TO_MEM_WD, MEM_TO_WB_WD, StallBus, LD_NONE/LB/LBU/LH/LHU/LW codes.
//  - Sub-module load_ext (combinational): in rdata[31:0], off[1:0], load_type[2:0]; out data[31:0].
//  - Top holds the pipeline register, hold buffer and output muxes.
// TESTING
//  1. Reset: resetn=0 for 2 cycles with garbage on the bus.
//     -> mem_to_wb_bus==0 and mem_to_id_bus==0 on the cycle after release.
//  2. ALU pass-through: rf_we=1, waddr=5, ex_result=0x1234_5678, ram_en=0.
//     -> one cycle later, mem_to_id_bus={1,5,0x12345678}.
//  3. Loads, each with rdata=0x80FF_7F01:
//       lb off=3 -> 0xFFFF_FF80;  lbu off=3 -> 0x0000_0080;  lh off=2 -> 0xFFFF_80FF
//       lhu off=0 -> 0x0000_7F01; lw -> 0x80FF_7F01
//  4. Stall hold: lw in MEM with rdata=0xDEAD_BEEF, stall[3]=stall[4]=1 for 3 cycles.
//     rdata changes to 0x0 after the first stalled cycle.
//     -> rf_wdata stays 0xDEADBEEF throughout and after release.
//  5. Bubble: stall[3]=1, stall[4]=0 -> next cycle rf_we=0, pc=0; WB receives no write.
//  6. Flush wins: flush=1 with stall=6'b001000 and a valid lw in MEM.
//     -> register and hold_valid clear; next cycle rf_we=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes and bus layouts for the MEM pipeline stage.
// The EX->MEM bus layout must match the EX stage packing bit for bit.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int STALL_BUS    = 6;
    localparam int STALL_MEM    = 3;
    localparam int STALL_WB     = 4;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } load_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [2:0]  load_type;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // ram_wen is dropped: the store was already issued from EX.
    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [2:0]  load_type;
        logic [31:0] ex_result;
    } mem_reg_t;

    // Codes 6 and 7 are reserved and behave like "no load".
    function automatic logic is_load_type(input logic [2:0] lt);
        return (lt >= LD_LB) && (lt <= LD_LW);
    endfunction

    function automatic mem_reg_t to_mem_reg(input ex_to_mem_t ex);
        mem_reg_t r;
        r.pc         = ex.pc;
        r.ram_en     = ex.ram_en;
        r.sel_rf_res = ex.sel_rf_res;
        r.rf_we      = ex.rf_we;
        r.rf_waddr   = ex.rf_waddr;
        r.load_type  = ex.load_type;
        r.ex_result  = ex.ex_result;
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data lane select and sign/zero extension for lb/lbu/lh/lhu/lw.
// Halfword selection ignores off[0]; misalignment is trapped upstream in EX.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lane[off];
        half_sel = off[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
        data     = rdata;
        case (load_type)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            LD_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: EX->MEM register, load data extension,
// SRAM read-data hold buffer for stalls, and the MEM->WB / MEM->ID buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic                    flush,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    ex_to_mem_t  ex_in;
    mem_reg_t    mem_q, mem_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_data_q, hold_data_d;

    logic        is_load;
    logic        bubble;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_bits;

    assign ex_in       = ex_to_mem_t'(ex_to_mem_bus);
    assign unused_bits = ^{ex_in.ram_wen, stall[STALL_BUS-1:STALL_WB+1], stall[STALL_MEM-1:0]};

    assign is_load = mem_q.ram_en & mem_q.sel_rf_res;
    assign bubble  = stall[STALL_MEM] & ~stall[STALL_WB];

    always_comb begin
        mem_d        = mem_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (flush || bubble) begin
            mem_d        = '0;
            hold_valid_d = 1'b0;
            hold_data_d  = '0;
        end else if (!stall[STALL_MEM]) begin
            mem_d        = to_mem_reg(ex_in);
            hold_valid_d = 1'b0;
        end else if (is_load && !hold_valid_q) begin
            // The SRAM only presents read data for one cycle; keep it for the stall.
            hold_valid_d = 1'b1;
            hold_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign load_src = hold_valid_q ? hold_data_q : data_sram_rdata;

    mem_stage_load_ext u_load_ext (
        .rdata     (load_src),
        .off       (mem_q.ex_result[1:0]),
        .load_type (mem_q.load_type),
        .data      (load_data)
    );

    assign rf_wdata = (is_load && is_load_type(mem_q.load_type)) ? load_data : mem_q.ex_result;

    assign mem_to_id_bus = {mem_q.rf_we, mem_q.rf_waddr, rf_wdata};
    assign mem_to_wb_bus = {mem_q.pc, mem_to_id_bus};

endmodule
